rate_sequencer: RTL and testbench
=================================

RATE_SEQUENCER -- requirements
Module: rate_sequencer

Interface
REQ-001 The block SHALL have parameter DEFAULT_SEL, default 5'd20, the tap selection loaded at reset.
REQ-002 The block SHALL have parameter CNT_W, default 32, the free-running counter width; legal tap values are 0..CNT_W-1.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port up_req  input  1  single-cycle request: target tap +1.
REQ-006 The block SHALL have port dn_req  input  1  single-cycle request: target tap -1.
REQ-007 The block SHALL have port load_req  input  1  single-cycle request: target tap = load_val.
REQ-008 The block SHALL have port load_val  input  5  absolute tap value for load_req.
REQ-009 The block SHALL have port hold  input  1  freeze: counter, ticks and commits paused while high.
REQ-010 The block SHALL have port tap_sel  output  5  currently active tap.
REQ-011 The block SHALL have port tick  output  1  registered single-cycle rate-enable pulse.
REQ-012 The block SHALL have port busy  output  1  high while a tap change is pending.
REQ-013 The block SHALL have port tick_count  output  16  number of ticks since reset, wrapping.

Function
REQ-014 The block SHALL hold a CNT_W-bit counter cnt that increments by 1 each cycle when hold=0 and wraps from all-ones to 0.
REQ-015 Tick condition T SHALL be true in a cycle when hold=0, cnt[k]=0 and cnt[k-1:0] is all ones, with k=tap_sel; for k=0 the condition is cnt[0]=0.
REQ-016 tick SHALL be 1 in the cycle after T is true and 0 otherwise, so at a steady tap k it pulses once every 2^(k+1) cycles.
REQ-017 tick_count SHALL increment by 1 on every cycle tick is 1 and wrap from 16'hFFFF to 0.
REQ-018 The FSM SHALL have two states: IDLE (busy=0) and PEND (busy=1); busy SHALL be a registered state decode.
REQ-019 Request priority SHALL be load_req > (up_req xor dn_req); up_req and dn_req both high without load_req SHALL be ignored.
REQ-020 The request base SHALL be tap_sel in IDLE and pend_sel in PEND, so that requests arriving in PEND coalesce into pend_sel.
REQ-021 up_req SHALL saturate at 31 and dn_req SHALL saturate at 0; a load_val above CNT_W-1 SHALL be clamped to CNT_W-1.
REQ-022 In IDLE, an accepted request whose result differs from tap_sel SHALL store the result in pend_sel and move to PEND; if the result equals tap_sel, the FSM SHALL stay in IDLE.
REQ-023 In PEND, on the edge where T is true, the block SHALL set tap_sel<=pend_sel and cnt<=0 instead of incrementing, still assert tick (the last tick at the old rate), and return to IDLE.
REQ-024 A request in the same cycle as a commit SHALL be evaluated against the new tap_sel, and SHALL send the FSM to PEND if its result differs from that value.
REQ-025 After a commit to tap m, the first tick SHALL occur 2^m cycles later, and then every 2^(m+1) cycles.
REQ-026 While hold=1, the block SHALL freeze cnt, tick SHALL stay 0, no commit SHALL occur, and requests SHALL still update pend_sel and the state.
REQ-027 A pending change SHALL wait indefinitely for its boundary; there SHALL be no timeout.

Reset
REQ-028 While rst_n=0, the block SHALL set cnt=0, tap_sel=DEFAULT_SEL, pend_sel=DEFAULT_SEL, state=IDLE, tick=0, busy=0, tick_count=0, with no clock required.
REQ-029 When rst_n is asserted mid-PEND, the pending change SHALL be discarded.
REQ-030 After rst_n deasserts, the first increment of cnt SHALL occur on the first rising clk edge.

Verification
REQ-031 The bench SHALL cover: DEFAULT_SEL=2, run 40 cycles -> tick at cnt=4,12,20,28,36, period 8, tick_count=5.
REQ-032 The bench SHALL cover: tap 2, up_req pulse at cnt=5 -> busy=1; commit at the next T (cnt=11->0); tap_sel=3; busy=0; next tick 8 cycles later, then every 16.
REQ-033 The bench SHALL cover: tap 1, three dn_req pulses while PEND -> pend_sel saturates at 0; single commit to tap_sel=0; ticks every 2 cycles.
REQ-034 The bench SHALL cover: load_req=1, up_req=1, load_val=5'd7 in one cycle -> pend_sel=7; up_req ignored; up_req=dn_req=1 alone -> no state change.
REQ-035 The bench SHALL cover: hold=1 for 20 cycles during PEND -> cnt is constant, no tick, no commit; after release, commit at the first T.
REQ-036 The bench SHALL cover: rst_n pulled low mid-PEND between clock edges -> outputs reach reset values immediately; tap_sel=DEFAULT_SEL; busy=0.

Source files
------------

// File: rtl/rate_sequencer.sv
// ============================================================================
// rate_sequencer
// Power-of-two rate-enable generator with glitch-free tap changes at tick
// boundaries.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rate_sequencer #(
  parameter logic [4:0] DEFAULT_SEL = 5'd20,
  parameter int         CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up_req,
  input  logic        dn_req,
  input  logic        load_req,
  input  logic [4:0]  load_val,
  input  logic        hold,
  output logic [4:0]  tap_sel,
  output logic        tick,
  output logic        busy,
  output logic [15:0] tick_count
);

  localparam logic [4:0]       c_MAX_SEL = (CNT_W - 1 > 31) ? 5'd31 : 5'(CNT_W - 1);
  localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_PEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       tap_sel_q, tap_sel_d;
  logic [4:0]       pend_sel_q, pend_sel_d;
  logic             tick_q, tick_d;
  logic [15:0]      tick_count_q, tick_count_d;

  logic [CNT_W-1:0] w_bit_mask;
  logic [CNT_W-1:0] w_low_mask;
  logic             w_t;
  logic             w_commit;
  logic [4:0]       w_base;
  logic [4:0]       w_cur_tap;
  logic             w_req_vld;
  logic [4:0]       w_req_val;

  // Boundary: selected bit clear and every bit below it set.
  assign w_bit_mask = c_ONE << tap_sel_q;
  assign w_low_mask = w_bit_mask - c_ONE;
  assign w_t        = !hold && ((cnt_q & w_bit_mask) == '0)
                      && ((cnt_q & w_low_mask) == w_low_mask);
  assign w_commit   = (state_q == c_PEND) && w_t;

  // In PEND the base is pend_sel, which is also the new tap on a commit edge.
  assign w_base    = (state_q == c_PEND) ? pend_sel_q : tap_sel_q;
  assign w_cur_tap = w_commit ? pend_sel_q : tap_sel_q;

  always_comb begin
    w_req_vld = 1'b0;
    w_req_val = w_base;
    if (load_req) begin
      w_req_vld = 1'b1;
      w_req_val = (load_val > c_MAX_SEL) ? c_MAX_SEL : load_val;
    end else if (up_req ^ dn_req) begin
      w_req_vld = 1'b1;
      if (up_req) begin
        w_req_val = (w_base >= c_MAX_SEL) ? c_MAX_SEL : w_base + 5'd1;
      end else begin
        w_req_val = (w_base == 5'd0) ? 5'd0 : w_base - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= c_IDLE;
      cnt_q        <= '0;
      tap_sel_q    <= DEFAULT_SEL;
      pend_sel_q   <= DEFAULT_SEL;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_sel_q    <= tap_sel_d;
      pend_sel_q   <= pend_sel_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_sel_d    = tap_sel_q;
    pend_sel_d   = pend_sel_q;
    tick_d       = w_t;
    tick_count_d = tick_q ? tick_count_q + 16'd1 : tick_count_q;

    if (w_commit) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = cnt_q + c_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    if (w_commit) begin
      tap_sel_d = pend_sel_q;
      state_d   = c_IDLE;
    end

    if (w_req_vld) begin
      if ((state_q == c_PEND) && !w_commit) begin
        pend_sel_d = w_req_val;
      end else if (w_req_val != w_cur_tap) begin
        pend_sel_d = w_req_val;
        state_d    = c_PEND;
      end
    end
  end

  always_comb begin
    busy       = (state_q == c_PEND);
    tap_sel    = tap_sel_q;
    tick       = tick_q;
    tick_count = tick_count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_rate_sequencer.sv
// ============================================================================
// tb_rate_sequencer
// Directed self-checking bench for rate_sequencer with DEFAULT_SEL = 2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rate_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up_req = 1'b0;
  logic        dn_req = 1'b0;
  logic        load_req = 1'b0;
  logic [4:0]  load_val = 5'd0;
  logic        hold = 1'b0;
  logic [4:0]  tap_sel;
  logic        tick;
  logic        busy;
  logic [15:0] tick_count;

  int checks = 0;
  int errors = 0;

  rate_sequencer #(
    .DEFAULT_SEL(5'd2),
    .CNT_W      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .up_req    (up_req),
    .dn_req    (dn_req),
    .load_req  (load_req),
    .load_val  (load_val),
    .hold      (hold),
    .tap_sel   (tap_sel),
    .tick      (tick),
    .busy      (busy),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Reset asserted between edges; released so the next posedge is edge 1.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    up_req   = 1'b0;
    dn_req   = 1'b0;
    load_req = 1'b0;
    load_val = 5'd0;
    hold     = 1'b0;
    #1;
    chk("rst_tap", tap_sel, 2);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_tcnt", tick_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Steady tap 2: ticks after edges 4,12,20,28,36.
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      step();
      chk($sformatf("s1_tick@%0d", n), tick, (n % 8 == 4));
    end
    chk("s1_tcnt", tick_count, 5);
    chk("s1_busy", busy, 0);

    // up_req while cnt=5, commit on the cnt=11 boundary, then tap 3.
    do_reset();
    steps(5);
    up_req = 1'b1;
    step();
    up_req = 1'b0;
    chk("s2_busy_set", busy, 1);
    chk("s2_tap_old", tap_sel, 2);
    steps(5);
    chk("s2_busy_wait", busy, 1);
    chk("s2_tick_wait", tick, 0);
    step();
    chk("s2_tap_new", tap_sel, 3);
    chk("s2_busy_clr", busy, 0);
    chk("s2_tick_commit", tick, 1);
    for (int n = 13; n <= 52; n++) begin
      step();
      chk($sformatf("s2_tick@%0d", n), tick, (n == 20 || n == 36 || n == 52));
    end

    // Load tap 1, then three dn_req in PEND saturating at 0.
    do_reset();
    load_req = 1'b1;
    load_val = 5'd1;
    step();
    load_req = 1'b0;
    chk("s3_busy_load", busy, 1);
    steps(2);
    chk("s3_tick_e3", tick, 0);
    step();
    chk("s3_tap1", tap_sel, 1);
    chk("s3_tick_e4", tick, 1);
    chk("s3_busy_e4", busy, 0);
    step();
    chk("s3_tick_e5", tick, 0);
    step();
    chk("s3_tick_e6", tick, 1);
    dn_req = 1'b1;
    step();
    chk("s3_busy_e7", busy, 1);
    steps(2);
    dn_req = 1'b0;
    chk("s3_busy_e9", busy, 1);
    chk("s3_tap_e9", tap_sel, 1);
    chk("s3_tick_e9", tick, 0);
    step();
    chk("s3_tap0", tap_sel, 0);
    chk("s3_busy_e10", busy, 0);
    chk("s3_tick_e10", tick, 1);
    for (int n = 11; n <= 20; n++) begin
      step();
      chk($sformatf("s3_tick@%0d", n), tick, (n % 2 == 1));
    end
    chk("s3_busy_run", busy, 0);
    dn_req = 1'b1;
    step();
    dn_req = 1'b0;
    chk("s3_dn_at0_busy", busy, 0);
    chk("s3_dn_at0_tap", tap_sel, 0);

    // load beats up; up+dn together ignored; up saturates at 31.
    do_reset();
    load_req = 1'b1;
    up_req   = 1'b1;
    load_val = 5'd7;
    step();
    load_req = 1'b0;
    up_req   = 1'b0;
    chk("s4_busy_load", busy, 1);
    steps(3);
    chk("s4_tap7", tap_sel, 7);
    chk("s4_busy_e4", busy, 0);
    chk("s4_tick_e4", tick, 1);
    up_req = 1'b1;
    dn_req = 1'b1;
    step();
    up_req = 1'b0;
    dn_req = 1'b0;
    chk("s4_both_busy", busy, 0);
    chk("s4_both_tap", tap_sel, 7);
    load_req = 1'b1;
    load_val = 5'd31;
    step();
    load_req = 1'b0;
    chk("s4_busy_l31", busy, 1);
    steps(125);
    chk("s4_busy_e131", busy, 1);
    chk("s4_tap_e131", tap_sel, 7);
    step();
    chk("s4_tap31", tap_sel, 31);
    chk("s4_busy_e132", busy, 0);
    chk("s4_tick_e132", tick, 1);
    up_req = 1'b1;
    step();
    up_req = 1'b0;
    chk("s4_upsat_busy", busy, 0);
    chk("s4_upsat_tap", tap_sel, 31);

    // Hold for 20 cycles in PEND; an up_req during hold retargets to 4.
    do_reset();
    up_req = 1'b1;
    step();
    up_req = 1'b0;
    hold   = 1'b1;
    chk("s5_busy_e1", busy, 1);
    for (int n = 2; n <= 21; n++) begin
      up_req = (n == 10);
      step();
      chk($sformatf("s5_hold_tick@%0d", n), tick, 0);
    end
    up_req = 1'b0;
    hold   = 1'b0;
    chk("s5_hold_busy", busy, 1);
    chk("s5_hold_tap", tap_sel, 2);
    step();
    chk("s5_tick_e22", tick, 0);
    step();
    chk("s5_tick_e23", tick, 0);
    chk("s5_busy_e23", busy, 1);
    step();
    chk("s5_tap4", tap_sel, 4);
    chk("s5_tick_e24", tick, 1);
    chk("s5_busy_e24", busy, 0);

    // Asynchronous reset mid-PEND discards the pending change.
    do_reset();
    steps(6);
    chk("s6_tcnt_pre", tick_count, 1);
    up_req = 1'b1;
    step();
    up_req = 1'b0;
    chk("s6_busy_pre", busy, 1);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_async_tap", tap_sel, 2);
    chk("s6_async_busy", busy, 0);
    chk("s6_async_tick", tick, 0);
    chk("s6_async_tcnt", tick_count, 0);
    @(posedge clk);
    #1;
    chk("s6_held_busy", busy, 0);
    rst_n = 1'b1;
    steps(3);
    chk("s6_tick_e3", tick, 0);
    step();
    chk("s6_tick_e4", tick, 1);
    steps(8);
    chk("s6_tap_e12", tap_sel, 2);
    chk("s6_busy_e12", busy, 0);
    chk("s6_tick_e12", tick, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
